// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a five-stage in-order pipeline. It resolves three
// hazards, from highest to lowest priority:
//   - multi-cycle multiply: freezes the front end while the multiply is in EX
//   - load-use: stalls IF/ID and inserts a bubble into ID/EX
//   - taken branch: flushes IF/ID
// All control outputs respond in the same cycle as their inputs. Only the
// FSM state, the multiply countdown and the stall counter are registered.
//
// Parameters
//   MUL_LAT         total EX occupancy of a multiply in cycles (2..15)
//
// Ports
//   clk_i           clock; all state updates on its rising edge
//   rst_i           asynchronous active-high reset
//   ID_RS1addr_i    rs1 index of the instruction in ID
//   ID_RS2addr_i    rs2 index of the instruction in ID
//   EX_MemRead_i    instruction in EX is a load
//   EX_RDaddr_i     rd index of the instruction in EX
//   EX_MulStart_i   instruction in EX is a multiply (held while it stays in EX)
//   Branch_taken_i  ID resolved a taken branch this cycle
//   PCWrite_o       PC update enable
//   IFIDWrite_o     IF/ID load enable
//   IFIDFlush_o     IF/ID clears to NOP
//   IDEXWrite_o     ID/EX load enable
//   IDEXBubble_o    ID/EX loads zeroed control fields
//   MulDone_o       one-cycle pulse: multiply result valid in EX
//   Busy_o          FSM is in the multiply-busy state
//   StallCount_o    saturating count of cycles with PCWrite_o low
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ID_RS1addr_i,
    input  logic [4:0]  ID_RS2addr_i,
    input  logic        EX_MemRead_i,
    input  logic [4:0]  EX_RDaddr_i,
    input  logic        EX_MulStart_i,
    input  logic        Branch_taken_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXWrite_o,
    output logic        IDEXBubble_o,
    output logic        MulDone_o,
    output logic        Busy_o,
    output logic [15:0] StallCount_o
);

    // The cycle that starts the multiply is its first hold cycle, so the
    // countdown loaded on entry covers the remaining EX cycles.
    localparam logic [3:0] MulLatM1 = 4'(MUL_LAT - 1);

    typedef enum logic [0:0] {
        StRun,
        StMulBusy
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q;

    logic load_use;
    logic mul_hold;
    logic mul_done;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    always_comb begin
        load_use = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
                   ((EX_RDaddr_i == ID_RS1addr_i) || (EX_RDaddr_i == ID_RS2addr_i));
    end

    // Next state and multiply hold/done decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_hold = 1'b0;
        mul_done = 1'b0;
        unique case (state_q)
            StRun: begin
                if (EX_MulStart_i) begin
                    mul_hold = 1'b1;
                    state_d  = StMulBusy;
                    cnt_d    = MulLatM1;
                end
            end
            StMulBusy: begin
                if (cnt_q > 4'd1) begin
                    mul_hold = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    // Final EX cycle: release the front end and evaluate the
                    // remaining hazards as in RUN.
                    mul_done = 1'b1;
                    state_d  = StRun;
                    cnt_d    = 4'd0;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pipeline control outputs, priority multiply > load-use > branch.
    always_comb begin
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IFIDFlush_o  = 1'b0;
        IDEXWrite_o  = 1'b1;
        IDEXBubble_o = 1'b0;
        if (rst_i) begin
            // Outputs stay at their idle values while reset is asserted.
        end else if (mul_hold) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            IDEXWrite_o = 1'b0;
        end else if (load_use) begin
            // A coincident taken branch is dropped; it re-resolves next cycle.
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
        end else if (Branch_taken_i) begin
            IFIDFlush_o = 1'b1;
        end
    end

    always_comb begin
        MulDone_o    = mul_done && !rst_i;
        Busy_o       = (state_q == StMulBusy) && !rst_i;
        StallCount_o = stall_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
        end else if (!PCWrite_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl (MUL_LAT = 4). Inputs change
// on the falling clock edge; outputs are sampled a few time units later,
// well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        mem_read, mul_start, branch;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic        mul_done, busy;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    // Reference state: the multiply's cycle index seen last cycle (0 = none)
    // and the number of stalled cycles so far.
    int m_prev_k = 0;
    int m_stalls = 0;

    pipeline_hazard_ctrl #(
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ID_RS1addr_i  (rs1),
        .ID_RS2addr_i  (rs2),
        .EX_MemRead_i  (mem_read),
        .EX_RDaddr_i   (rd),
        .EX_MulStart_i (mul_start),
        .Branch_taken_i(branch),
        .PCWrite_o     (pc_write),
        .IFIDWrite_o   (ifid_write),
        .IFIDFlush_o   (ifid_flush),
        .IDEXWrite_o   (idex_write),
        .IDEXBubble_o  (idex_bubble),
        .MulDone_o     (mul_done),
        .Busy_o        (busy),
        .StallCount_o  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic [4:0] exp;  // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble}
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic mr,
                         input logic [4:0] d, input logic mul, input logic br);
        rs1       = a;
        rs2       = b;
        mem_read  = mr;
        rd        = d;
        mul_start = mul;
        branch    = br;
    endtask

    // Expected {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, MulDone,
    // Busy} derived from the hazard rules and the multiply's cycle index k.
    task automatic model(output logic [6:0] e, output int k);
        logic lu;
        logic hold;
        k    = (m_prev_k > 0) ? m_prev_k + 1 : (mul_start ? 1 : 0);
        lu   = mem_read && (rd != 0) && (rd == rs1 || rd == rs2);
        hold = (k >= 1) && (k < MUL_LAT);
        if (hold)        e[6:2] = 5'b00010 & 5'b00000;
        else if (lu)     e[6:2] = 5'b00011;
        else if (branch) e[6:2] = 5'b11110;
        else             e[6:2] = 5'b11010;
        e[1] = (k == MUL_LAT);
        e[0] = (k >= 2);
    endtask

    // Check all outputs against the model, then advance through one clock.
    task automatic step(input string tag);
        logic [6:0] e;
        int         k;
        #2;
        model(e, k);
        check({tag, ":ctl"},
              int'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mul_done, busy}),
              int'(e));
        check({tag, ":stalls"}, int'(stall_count), m_stalls);
        @(posedge clk);
        #1;
        if (!e[6] && m_stalls < 65535) m_stalls++;
        m_prev_k = (k >= 1 && k < MUL_LAT) ? k : 0;
        @(negedge clk);
    endtask

    initial begin
        int s0;

        vecs[0] = '{5'd1, 5'd2, 1'b0, 5'd1, 1'b0, 5'b11010};  // no load
        vecs[1] = '{5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 5'b00011};  // load-use on rs2
        vecs[2] = '{5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'b11010};  // x0 exemption
        vecs[3] = '{5'd4, 5'd2, 1'b1, 5'd4, 1'b0, 5'b00011};  // load-use on rs1
        vecs[4] = '{5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 5'b11010};  // load, no match
        vecs[5] = '{5'd1, 5'd2, 1'b0, 5'd1, 1'b1, 5'b11110};  // taken branch
        vecs[6] = '{5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 5'b00011};  // branch + load-use
        vecs[7] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'b11110};  // branch, x0 load

        // Reset with hazard-provoking inputs: outputs must stay idle.
        rst = 1'b1;
        drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        #3;
        check("reset_ctl",
              int'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mul_done, busy}),
              int'(7'b1101000));
        @(posedge clk);
        #1;
        check("reset_stalls", int'(stall_count), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table-driven single-cycle hazard decode.
        foreach (vecs[i]) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].rd, 1'b0, vecs[i].br);
            #1;
            check($sformatf("vec%0d", i),
                  int'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}),
                  int'(vecs[i].exp));
            step($sformatf("vec%0d_model", i));
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("idle0");

        // Load-use increments the stall counter by one.
        s0 = m_stalls;
        drive(5'd9, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        step("lu");
        check("lu_stall_incr", int'(stall_count), s0 + 1);

        // x0 exemption.
        drive(5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        check("x0_pcwrite", int'(pc_write), 1);
        step("x0");

        // Multiply: 3 hold cycles, done pulse on cycle 4, busy cycles 2..4.
        s0 = m_stalls;
        for (int c = 1; c <= MUL_LAT; c++) begin
            drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
            #1;
            check($sformatf("mul_c%0d_pcwrite", c), int'(pc_write), (c < MUL_LAT) ? 0 : 1);
            check($sformatf("mul_c%0d_done", c), int'(mul_done), (c == MUL_LAT) ? 1 : 0);
            check($sformatf("mul_c%0d_busy", c), int'(busy), (c >= 2) ? 1 : 0);
            step($sformatf("mul_c%0d", c));
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("mul_stall_delta", int'(stall_count) - s0, MUL_LAT - 1);
        check("mul_after_done", int'(mul_done), 0);
        step("mul_after");

        // Branch with load-use: stall wins, branch flushes the following cycle.
        drive(5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b1);
        #1;
        check("brlu_flush", int'(ifid_flush), 0);
        check("brlu_pcwrite", int'(pc_write), 0);
        step("brlu");
        drive(5'd7, 5'd1, 1'b0, 5'd7, 1'b0, 1'b1);
        #1;
        check("br_retry_flush", int'(ifid_flush), 1);
        step("br_retry");

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30));
            step("rand");
        end

        // Drain any multiply in flight.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i <= MUL_LAT; i++) step("drain");

        // Saturation: hold load-use long enough to pass 16'hFFFF.
        drive(5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
        repeat (65540) @(negedge clk);
        m_stalls = 65535;
        check("sat_value", int'(stall_count), 65535);
        for (int i = 0; i < 3; i++) step("sat_hold");

        // Asynchronous reset during multiply cycle 2.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("pre_mul");
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        step("rmul_c1");
        #1;
        check("rmul_busy_before", int'(busy), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rmul_busy_async", int'(busy), 0);
        check("rmul_stalls_async", int'(stall_count), 0);
        check("rmul_pcwrite_async", int'(pc_write), 1);
        check("rmul_done_async", int'(mul_done), 0);
        @(posedge clk);
        #1;
        check("rmul_busy_held", int'(busy), 0);
        check("rmul_stalls_held", int'(stall_count), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        m_prev_k = 0;
        m_stalls = 0;
        for (int i = 0; i <= MUL_LAT; i++) step("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, range 2..15: total EX-stage occupancy in cycles of a multiply instruction.
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on posedge clk_i.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ID_RS1addr_i  in  5  rs1 index of the instruction in ID.
REQ-005 SHALL have port ID_RS2addr_i  in  5  rs2 index of the instruction in ID.
REQ-006 SHALL have port EX_MemRead_i  in  1  instruction in EX is a load.
REQ-007 SHALL have port EX_RDaddr_i  in  5  rd index of the instruction in EX.
REQ-008 SHALL have port EX_MulStart_i  in  1  instruction in EX is a multiply; held high while the instruction stays in EX.
REQ-009 SHALL have port Branch_taken_i  in  1  ID has resolved a taken branch this cycle.
REQ-010 SHALL have port PCWrite_o  out  1  PC update enable.
REQ-011 SHALL have port IFIDWrite_o  out  1  IF/ID register load enable.
REQ-012 SHALL have port IFIDFlush_o  out  1  IF/ID register clears to NOP.
REQ-013 SHALL have port IDEXWrite_o  out  1  ID/EX register load enable.
REQ-014 SHALL have port IDEXBubble_o  out  1  ID/EX loads zeros into RegWrite/MemtoReg/MemRead/MemWrite/ALUSrc/ALUOp.
REQ-015 SHALL have port MulDone_o  out  1  one-cycle pulse: multiply result valid in EX this cycle.
REQ-016 SHALL have port Busy_o  out  1  FSM is in MUL_BUSY.
REQ-017 SHALL have port StallCount_o  out  16  count of cycles with PCWrite_o=0.

Function
REQ-018 SHALL implement FSM states RUN and MUL_BUSY plus a 4-bit down-counter cnt.
REQ-019 SHALL define LU (load-use) = EX_MemRead_i & (EX_RDaddr_i!=0) & (EX_RDaddr_i==ID_RS1addr_i | EX_RDaddr_i==ID_RS2addr_i).
REQ-020 SHALL drive all outputs combinationally from current state, cnt and inputs (same-cycle response), with priority MUL hold > LU stall > branch flush.
REQ-021 SHALL, in RUN with EX_MulStart_i=1: PCWrite_o=0, IFIDWrite_o=0, IDEXWrite_o=0, IDEXBubble_o=0, IFIDFlush_o=0; next state MUL_BUSY, cnt<=MUL_LAT-1.
REQ-022 SHALL, in MUL_BUSY with cnt>1: same hold outputs as REQ-021, cnt decrements, EX_MulStart_i/LU/Branch_taken_i ignored.
REQ-023 SHALL, in MUL_BUSY with cnt==1: MulDone_o=1, hold released (outputs evaluated as RUN with EX_MulStart_i treated as 0), next state RUN, cnt<=0.
REQ-024 SHALL thus hold the front end exactly MUL_LAT-1 cycles per multiply; MUL_LAT=2 gives 1 hold cycle then done.
REQ-025 SHALL, in RUN with LU=1 and no multiply: PCWrite_o=0, IFIDWrite_o=0, IDEXWrite_o=1, IDEXBubble_o=1, IFIDFlush_o=0.
REQ-026 SHALL, in RUN with Branch_taken_i=1, LU=0, no multiply: IFIDFlush_o=1, all write enables 1, IDEXBubble_o=0.
REQ-027 SHALL, on Branch_taken_i together with LU, suppress the flush (stall wins; branch re-resolves next cycle).
REQ-028 SHALL, otherwise, drive PCWrite_o=IFIDWrite_o=IDEXWrite_o=1 and IFIDFlush_o=IDEXBubble_o=MulDone_o=0.
REQ-029 SHALL increment StallCount_o on each posedge where PCWrite_o=0, saturating at 16'hFFFF (no wrap).
REQ-030 SHALL drive Busy_o=1 exactly while state is MUL_BUSY.

Reset
REQ-031 SHALL, on rst_i high, immediately set state=RUN, cnt=0, StallCount_o=0, independent of clk_i.
REQ-032 SHALL, while rst_i high, force PCWrite_o=IFIDWrite_o=IDEXWrite_o=1 and IFIDFlush_o=IDEXBubble_o=MulDone_o=Busy_o=0.
REQ-033 SHALL, on reset asserted mid-multiply, abandon the count; after release the FSM starts in RUN without a MulDone_o pulse.

Verification
REQ-034 SHALL cover load-use: EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS2addr_i=5 -> PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1 same cycle; StallCount_o 0->1.
REQ-035 SHALL cover x0 exemption: EX_MemRead_i=1, EX_RDaddr_i=0, ID_RS1addr_i=0 -> no stall, PCWrite_o=1.
REQ-036 SHALL cover multiply MUL_LAT=4: EX_MulStart_i held -> hold 3 cycles, MulDone_o pulse in cycle 4, Busy_o high cycles 2-4, StallCount_o +3.
REQ-037 SHALL cover branch+LU: Branch_taken_i=1 with LU=1 -> IFIDFlush_o=0, stall; next cycle LU=0, Branch_taken_i=1 -> IFIDFlush_o=1.
REQ-038 SHALL cover saturation: preload via 65535 stall cycles -> StallCount_o stays 16'hFFFF after further stalls.
REQ-039 SHALL cover async reset at multiply cycle 2 -> Busy_o=0 and StallCount_o=0 before next clk edge; no MulDone_o afterwards.
